alu_cmd_sequencer: RTL and testbench

//  Initiator-side front end for the 32-bit 8-op registered ALU.
//  - Accepts tagged commands (op, a, b) on a valid/ready port and buffers them in a small FIFO.
//  - Drives the ALU operand/select ports one command at a time and captures alu_out after its 1-cycle latency.
//  - Returns each tagged result on a valid/ready response port.
//  - Sits between the bus-side command source and the ALU datapath.

---
 rtl/alu_cmd_sequencer_pkg.sv | 44 ++++
 rtl/alu_cmd_fifo.sv | 54 +++++
 rtl/alu_cmd_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared ALU definitions for the command sequencer: widths, opcodes, FSM states
// and a behavioural ALU function used by the optional result checker.
package alu_cmd_sequencer_pkg;

  localparam int unsigned ALU_DW  = 32;
  localparam int unsigned ALU_OPW = 3;

  typedef enum logic [ALU_OPW-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOTA = 3'b101,
    OP_SHR  = 3'b110,
    OP_SHL  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } seq_state_e;

  // Shift amounts use the full 32-bit b, so b >= 32 yields zero.
  function automatic logic [ALU_DW-1:0] alu_ref(input logic [ALU_OPW-1:0] op,
                                                input logic [ALU_DW-1:0]  a,
                                                input logic [ALU_DW-1:0]  b);
    logic [ALU_DW-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOTA: r = ~a;
      OP_SHR:  r = a >> b;
      default: r = a << b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with full/empty/count status; DEPTH must be a power of 2.
module alu_cmd_fifo #(
  parameter int unsigned WIDTH = 71,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front end for the registered 8-op ALU: FIFO-buffered tagged commands,
// one in flight, in-order tagged responses. Define ALU_SEQ_CHECK_EN for the result checker.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ALU_OPW-1:0]  cmd_op,
  input  logic [ALU_DW-1:0]   cmd_a,
  input  logic [ALU_DW-1:0]   cmd_b,
  input  logic [TAG_W-1:0]    cmd_tag,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ALU_DW-1:0]   rsp_data,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic [ALU_DW-1:0]   alu_a,
  output logic [ALU_DW-1:0]   alu_b,
  output logic [ALU_OPW-1:0]  alu_s,
  output logic                alu_rst,
  input  logic [ALU_DW-1:0]   alu_out,
  output logic                busy,
  output logic                chk_err
);

  localparam int unsigned FW = ALU_OPW + 2 * ALU_DW + TAG_W;

  seq_state_e          r_state;
  logic [TAG_W-1:0]    r_tag;
  logic [ALU_DW-1:0]   r_alu_a;
  logic [ALU_DW-1:0]   r_alu_b;
  logic [ALU_OPW-1:0]  r_alu_s;
  logic                r_rsp_valid;
  logic [ALU_DW-1:0]   r_rsp_data;
  logic [TAG_W-1:0]    r_rsp_tag;

  logic [FW-1:0]       w_fifo_rdata;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [$clog2(DEPTH):0] w_fifo_count;
  logic                w_pop;
  logic [ALU_OPW-1:0]  w_head_op;
  logic [ALU_DW-1:0]   w_head_a;
  logic [ALU_DW-1:0]   w_head_b;
  logic [TAG_W-1:0]    w_head_tag;

  alu_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (cmd_valid),
    .i_wdata ({cmd_op, cmd_a, cmd_b, cmd_tag}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_head_tag = w_fifo_rdata[TAG_W-1:0];
  assign w_head_b   = w_fifo_rdata[TAG_W +: ALU_DW];
  assign w_head_a   = w_fifo_rdata[TAG_W + ALU_DW +: ALU_DW];
  assign w_head_op  = w_fifo_rdata[TAG_W + 2 * ALU_DW +: ALU_OPW];

  // The head is consumed from IDLE, or from RESP on the same edge the response handshakes.
  assign w_pop = !w_fifo_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tag       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_s     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
    end else begin
      if (w_pop) begin
        r_alu_a <= w_head_a;
        r_alu_b <= w_head_b;
        r_alu_s <= w_head_op;
        r_tag   <= w_head_tag;
      end
      case (r_state)
        ST_IDLE:  if (w_pop) r_state <= ST_ISSUE;
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          r_rsp_data  <= alu_out;
          r_rsp_tag   <= r_tag;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_pop ? ST_ISSUE : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = !w_fifo_full;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_tag   = r_rsp_tag;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_s     = r_alu_s;
  assign alu_rst   = rst;
  assign busy      = (w_fifo_count != '0) || (r_state != ST_IDLE);

`ifdef ALU_SEQ_CHECK_EN
  logic [ALU_DW-1:0] r_exp;
  logic              r_chk_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp     <= '0;
      r_chk_err <= 1'b0;
    end else begin
      if (w_pop) r_exp <= alu_ref(w_head_op, w_head_a, w_head_b);
      if ((r_state == ST_WAIT) && (alu_out != r_exp)) r_chk_err <= 1'b1;
    end
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural registered ALU attached.
module tb_alu_cmd_sequencer;

`ifdef ALU_SEQ_CHECK_EN
  localparam logic EXP_CHK = 1'b1;
`else
  localparam logic EXP_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_s;
  logic        alu_rst;
  logic [31:0] alu_out;
  logic        busy;
  logic        chk_err;

  logic        corrupt = 1'b0;
  logic        rnd_ready = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          n_rsp = 0;
  int          full_cycles = 0;
  logic [35:0] exp_q [$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .DEPTH (4),
    .TAG_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_tag   (cmd_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_rst   (alu_rst),
    .alu_out   (alu_out),
    .busy      (busy),
    .chk_err   (chk_err)
  );

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return (b >= 32) ? 32'd0 : (a >> b[4:0]);
      default: return (b >= 32) ? 32'd0 : (a << b[4:0]);
    endcase
  endfunction

  // Registered ALU with one cycle of latency; corrupt flips bit 0 of its result.
  always @(posedge clk) begin
    if (alu_rst) alu_out <= '0;
    else         alu_out <= model(alu_s, alu_a, alu_b) ^ {31'd0, corrupt};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Command-side monitor: every accepted command pushes its expected response.
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (!cmd_ready) full_cycles++;
      if (cmd_valid && cmd_ready)
        exp_q.push_back({cmd_tag, model(cmd_op, cmd_a, cmd_b) ^ {31'd0, corrupt}});
    end
  end

  // Response-side monitor: every response handshake pops and compares.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got tag=%h data=%h expected no response", rsp_tag, rsp_data);
      end else begin
        check("rsp_order", {28'd0, rsp_tag, rsp_data}, {28'd0, exp_q.pop_front()});
      end
      n_rsp++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        tick();
        cmd_valid = 1'b0;
        return;
      end
      tick();
    end
    checks++;
    failures++;
    $display("FAIL send_timeout: got cmd_ready=0 expected acceptance of tag %h", tag);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      tick();
      if (!busy && !rsp_valid && exp_q.size() == 0) return;
    end
    checks++;
    failures++;
    $display("FAIL idle_timeout: got busy=%b pending=%0d expected idle", busy, exp_q.size());
  endtask

  initial begin
    int n0;
    int f0;
    int vcount;
    logic got;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_tag, rsp_data}, 0);
    check("rst_alu_regs", {alu_s, alu_a, alu_b}, 0);
    check("rst_busy_chk", {busy, chk_err}, 0);
    check("rst_alu_rst", alu_rst, 1);
    rst = 1'b0;
    tick();

    // 1: single add, latency after third edge
    send(3'd0, 32'd5, 32'd7, 4'd3);
    tick(); tick();
    check("lat_e2_valid", rsp_valid, 0);
    tick();
    check("lat_e3_rsp", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 4'd3, 32'd12});
    wait_idle();

    // 2: burst of 6 with corner values
    f0 = full_cycles; n0 = n_rsp;
    send(3'd1, 32'd0, 32'd1, 4'd1);
    send(3'd5, 32'd0, 32'hDEAD_BEEF, 4'd2);
    send(3'd7, 32'd1, 32'd31, 4'd3);
    send(3'd7, 32'd1, 32'd32, 4'd4);
    send(3'd6, 32'h8000_0000, 32'd40, 4'd5);
    send(3'd0, 32'hFFFF_FFFF, 32'd2, 4'd6);
    wait_idle();
    check("burst_full_seen", (full_cycles > f0), 1);
    check("burst_count", n_rsp - n0, 6);

    // 3: backpressure with two queued commands
    rsp_ready = 1'b0;
    send(3'd0, 32'd100, 32'd23, 4'd4);
    send(3'd1, 32'd50, 32'd8, 4'd5);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rsp_valid) begin got = 1'b1; break; end
    end
    check("bp_first_valid", got, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold", {rsp_valid, rsp_tag, rsp_data}, {1'b1, exp_q[0]});
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_second_not_yet", rsp_valid, 0);
    wait_idle();

    // 6: checker sees a single bad ALU result
    corrupt = 1'b1;
    send(3'd0, 32'd1, 32'd2, 4'd9);
    wait_idle();
    corrupt = 1'b0;
    check("chk_err_set", chk_err, EXP_CHK);
    send(3'd2, 32'hF0F0, 32'hFF00, 4'd10);
    wait_idle();
    check("chk_err_sticky", chk_err, EXP_CHK);

    // 4: reset while the first command sits in WAIT with two queued
    send(3'd0, 32'd11, 32'd22, 4'd1);
    send(3'd3, 32'd12, 32'd3, 4'd2);
    send(3'd4, 32'd13, 32'd5, 4'd7);
    rst = 1'b1;
    tick();
    check("rstmid_outputs", {rsp_valid, busy, cmd_ready, chk_err, alu_rst}, 5'b00101);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid || busy) vcount++;
    end
    check("rstmid_no_stale", vcount, 0);

    // 5: continuous stream, tags 0..7, push and pop coincide at DEPTH-1
    n0 = n_rsp;
    for (int t = 0; t < 8; t++) send(3'($urandom_range(0, 7)), $urandom, 32'($urandom_range(0, 40)), 4'(t));
    wait_idle();
    check("stream_count", n_rsp - n0, 8);

    // Random traffic with random response backpressure
    n0 = n_rsp;
    rnd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(3'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)), 4'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    rnd_ready = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    check("random_count", n_rsp - n0, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
